// File: rtl/ast_tensor_driver_sv_if.sv
// Bundle between the tensor job driver and its neighbours: the host command
// port, the input element stream, the result stream, job status and the
// accelerator load/start/read port.
//  master : the driver side (drives cmd_ready, in_ready, out_*, job_*, t_* controls)
//  slave  : the environment side (host, consumer and accelerator)
interface ast_tensor_driver_sv_if #(
  parameter int unsigned DATAWIDTH = 14,
  parameter int unsigned SIZE      = 4
);
  localparam int unsigned DIMW = $clog2(SIZE) + 1;

  // host command
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DIMW-1:0]      cmd_q;
  logic [DIMW-1:0]      cmd_r;
  logic [DIMW-1:0]      cmd_k;
  logic                 cmd_bias;
  logic                 cmd_relu;
  // input element stream
  logic                 in_valid;
  logic [DATAWIDTH-1:0] in_data;
  logic                 in_ready;
  // result stream
  logic                 out_valid;
  logic [DATAWIDTH-1:0] out_data;
  logic                 out_last;
  logic                 out_ready;
  // job status
  logic                 job_done;
  logic                 job_err;
  // accelerator port
  logic [DATAWIDTH-1:0] t_data_in;
  logic                 t_wen;
  logic [1:0]           t_set;
  logic [DIMW-1:0]      t_depth;
  logic [DIMW-1:0]      t_width;
  logic                 t_relu;
  logic                 t_start;
  logic                 t_ren;
  logic [DATAWIDTH-1:0] t_data_out;
  logic                 t_busy;
  logic                 t_done;

  modport master (
    input  cmd_valid, cmd_q, cmd_r, cmd_k, cmd_bias, cmd_relu,
    input  in_valid, in_data, out_ready,
    input  t_data_out, t_busy, t_done,
    output cmd_ready, in_ready, out_valid, out_data, out_last,
    output job_done, job_err,
    output t_data_in, t_wen, t_set, t_depth, t_width, t_relu, t_start, t_ren
  );

  modport slave (
    output cmd_valid, cmd_q, cmd_r, cmd_k, cmd_bias, cmd_relu,
    output in_valid, in_data, out_ready,
    output t_data_out, t_busy, t_done,
    input  cmd_ready, in_ready, out_valid, out_data, out_last,
    input  job_done, job_err,
    input  t_data_in, t_wen, t_set, t_depth, t_width, t_relu, t_start, t_ren
  );
endinterface

// File: rtl/ast_tensor_driver_sv.sv
// Host-side initiator for the tensor systolic accelerator. Accepts one
// A*B(+W) job, streams A, B and optional W into the accelerator load port,
// pulses start, waits for done, then drains Q*K results onto a valid/ready
// output stream.
//  clk, reset : clock, synchronous active-high reset
//  bus        : master view of ast_tensor_driver_sv_if (command, input stream,
//               result stream, job status, accelerator port)
// All outputs are registered except t_ren, which must pop the accelerator
// result head in the same cycle the output register frees up.
module ast_tensor_driver_sv #(
  parameter int unsigned DATAWIDTH = 14,
  parameter int unsigned SIZE      = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  ast_tensor_driver_sv_if.master bus
);
  localparam int unsigned DIMW = $clog2(SIZE) + 1;
  localparam int unsigned CNTW = 2 * DIMW;
  localparam int unsigned TMRW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_W, S_START, S_WAIT, S_SETTLE, S_READ, S_FIN
  } state_e;

  state_e               state_q;
  logic [DIMW-1:0]      q_q, r_q, k_q;
  logic                 bias_q;
  logic [CNTW-1:0]      cnt_q;
  logic [TMRW-1:0]      tmr_q;
  logic                 cmd_ready_q, in_ready_q;
  logic                 out_valid_q, out_last_q;
  logic [DATAWIDTH-1:0] out_data_q;
  logic                 job_done_q, job_err_q;
  logic [DATAWIDTH-1:0] t_data_in_q;
  logic                 t_wen_q, t_relu_q, t_start_q;
  logic [1:0]           t_set_q;
  logic [DIMW-1:0]      t_depth_q, t_width_q;

  // Per-phase accelerator load parameters for the current LOAD state
  logic [1:0]      ph_set_d;
  logic [DIMW-1:0] ph_depth_d, ph_width_d;
  logic [CNTW-1:0] ph_total_d;

  always_comb begin
    ph_set_d   = 2'd0;
    ph_depth_d = r_q;
    ph_width_d = q_q;
    case (state_q)
      S_LOAD_B: begin ph_set_d = 2'd1; ph_depth_d = k_q; ph_width_d = r_q; end
      S_LOAD_W: begin ph_set_d = 2'd3; ph_depth_d = k_q; ph_width_d = q_q; end
      default:  ;
    endcase
    ph_total_d = CNTW'(ph_depth_d) * CNTW'(ph_width_d);
  end

  logic [CNTW-1:0] rd_total_c;
  logic            dims_ok_c, in_fire_c, out_fire_c, t_ren_c;

  assign rd_total_c = CNTW'(q_q) * CNTW'(k_q);
  assign dims_ok_c  = (bus.cmd_q != '0) && (bus.cmd_q <= DIMW'(SIZE)) &&
                      (bus.cmd_r != '0) && (bus.cmd_r <= DIMW'(SIZE)) &&
                      (bus.cmd_k != '0) && (bus.cmd_k <= DIMW'(SIZE));
  assign in_fire_c  = bus.in_valid & in_ready_q;
  assign out_fire_c = out_valid_q & bus.out_ready;
  // Pop a result whenever the 1-entry output register is empty or draining
  assign t_ren_c    = (state_q == S_READ) && (cnt_q != rd_total_c) &&
                      (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      r_q         <= '0;
      k_q         <= '0;
      bias_q      <= 1'b0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      job_done_q  <= 1'b0;
      job_err_q   <= 1'b0;
      t_data_in_q <= '0;
      t_wen_q     <= 1'b0;
      t_relu_q    <= 1'b0;
      t_start_q   <= 1'b0;
      t_set_q     <= '0;
      t_depth_q   <= '0;
      t_width_q   <= '0;
    end else begin
      t_wen_q    <= 1'b0;
      t_start_q  <= 1'b0;
      job_done_q <= 1'b0;

      // Accepted element is written one cycle later with its phase descriptor
      if (in_fire_c) begin
        t_wen_q     <= 1'b1;
        t_data_in_q <= bus.in_data;
        t_set_q     <= ph_set_d;
        t_depth_q   <= ph_depth_d;
        t_width_q   <= ph_width_d;
      end

      // Output register: refill on pop, otherwise empty on handshake
      if (t_ren_c) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.t_data_out;
        out_last_q  <= (cnt_q == rd_total_c - CNTW'(1));
      end else if (out_fire_c) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            job_err_q <= 1'b0;
            cnt_q     <= '0;
            if (!dims_ok_c) begin
              job_err_q  <= 1'b1;
              job_done_q <= 1'b1;
            end else begin
              q_q         <= bus.cmd_q;
              r_q         <= bus.cmd_r;
              k_q         <= bus.cmd_k;
              bias_q      <= bus.cmd_bias;
              t_relu_q    <= bus.cmd_relu;
              cmd_ready_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A, S_LOAD_B, S_LOAD_W: begin
          if (in_fire_c) begin
            if (cnt_q == ph_total_d - CNTW'(1)) begin
              cnt_q <= '0;
              if (state_q == S_LOAD_A) begin
                state_q <= S_LOAD_B;
              end else if (state_q == S_LOAD_B && bias_q) begin
                state_q <= S_LOAD_W;
              end else begin
                in_ready_q <= 1'b0;
                state_q    <= S_START;
              end
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        // Hold off until the last write has retired and the array is idle
        S_START: begin
          if (!t_wen_q && !bus.t_busy) begin
            t_start_q <= 1'b1;
            tmr_q     <= '0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.t_done) begin
            state_q <= S_SETTLE;
          end else if (tmr_q == TMRW'(TIMEOUT - 1)) begin
            job_err_q   <= 1'b1;
            job_done_q  <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TMRW'(1);
          end
        end
        // One idle cycle lets the result FIFOs parallel-load
        S_SETTLE: begin
          cnt_q   <= '0;
          state_q <= S_READ;
        end
        S_READ: begin
          if (t_ren_c) cnt_q <= cnt_q + CNTW'(1);
          if (out_fire_c && out_last_q) begin
            job_done_q <= 1'b1;
            state_q    <= S_FIN;
          end
        end
        S_FIN: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.job_done  = job_done_q;
  assign bus.job_err   = job_err_q;
  assign bus.t_data_in = t_data_in_q;
  assign bus.t_wen     = t_wen_q;
  assign bus.t_set     = t_set_q;
  assign bus.t_depth   = t_depth_q;
  assign bus.t_width   = t_width_q;
  assign bus.t_relu    = t_relu_q;
  assign bus.t_start   = t_start_q;
  assign bus.t_ren     = t_ren_c;
endmodule

// File: tb/tb_ast_tensor_driver_sv.sv
// Bench for ast_tensor_driver_sv: behavioural accelerator, host driver,
// randomized consumer and a matrix-arithmetic scoreboard.
module tb_ast_tensor_driver_sv;
  localparam int unsigned DW      = 14;
  localparam int unsigned SIZE    = 4;
  localparam int unsigned DIMW    = $clog2(SIZE) + 1;
  localparam int unsigned TIMEOUT = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ast_tensor_driver_sv_if #(.DATAWIDTH(DW), .SIZE(SIZE)) bus ();
  ast_tensor_driver_sv #(.DATAWIDTH(DW), .SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // C[i][j] = sum_m A[i][m]*B[m][j] (+W[i][j]), row-major, truncated, optional ReLU
  function automatic logic [DW-1:0] mac(input logic [DW-1:0] a[16], input logic [DW-1:0] b[16],
                                        input logic [DW-1:0] w[16], input int i, input int j,
                                        input int r, input int k, input bit bias, input bit relu);
    logic [31:0] s;
    s = bias ? 32'(w[i*k+j]) : 32'd0;
    for (int m = 0; m < r; m++) s += 32'(a[i*r+m]) * 32'(b[m*k+j]);
    mac = s[DW-1:0];
    if (relu && mac[DW-1]) mac = '0;
  endfunction

  // ---------------- behavioural accelerator ----------------
  logic [DW-1:0] a_mem[16], b_mem[16], w_mem[16], r_mem[16];
  int na, nb, nw, rd_idx, hold_cnt, comp_cnt, busy_viol = 0;
  int jq, jr, jk;
  bit hang = 0;
  logic done_r;
  assign bus.t_busy     = (hold_cnt != 0) || (comp_cnt != 0);
  assign bus.t_done     = done_r;
  assign bus.t_data_out = r_mem[rd_idx[3:0]];

  always @(posedge clk) begin
    if (reset) begin
      na <= 0; nb <= 0; nw <= 0; rd_idx <= 0; hold_cnt <= 0; comp_cnt <= 0; done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
      if (bus.t_wen) begin
        hold_cnt <= $urandom_range(0, 3);
        case (bus.t_set)
          2'd0: begin a_mem[na[3:0]] <= bus.t_data_in; na <= na + 1; end
          2'd1: begin b_mem[nb[3:0]] <= bus.t_data_in; nb <= nb + 1; end
          2'd3: begin w_mem[nw[3:0]] <= bus.t_data_in; nw <= nw + 1; end
          default: ;
        endcase
      end
      if (comp_cnt != 0) begin
        comp_cnt <= comp_cnt - 1;
        if (comp_cnt == 1) done_r <= 1'b1;
      end
      if (bus.t_start) begin
        if (bus.t_busy) busy_viol <= busy_viol + 1;
        for (int i = 0; i < jq; i++)
          for (int j = 0; j < jk; j++)
            r_mem[i*jk+j] <= mac(a_mem, b_mem, w_mem, i, j, jr, jk, nw != 0, bus.t_relu);
        na <= 0; nb <= 0; nw <= 0; rd_idx <= 0;
        if (!hang) comp_cnt <= $urandom_range(2, 6);
      end
      if (bus.t_ren) rd_idx <= rd_idx + 1;
    end
  end

  // ---------------- consumer ----------------
  bit rdy_rand = 0;
  int stall_req = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_req > 0) begin
        bus.out_ready = 1'b0;
        stall_req--;
      end else begin
        bus.out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW:0]     exp_q[$];
  logic [1:0]      drv_set;
  logic [DIMW-1:0] drv_dep, drv_wid;
  int n_wen = 0, n_start = 0, n_ren = 0, n_done = 0, start_cyc = 0, done_cyc = 0;
  bit prev_fire = 0, prev_hold = 0;
  logic [DW-1:0]   prev_din, prev_odata;
  logic [1:0]      prev_set;
  logic [DIMW-1:0] prev_dep, prev_wid;
  logic [DW:0]     e;

  always @(negedge clk) begin
    if (reset) begin
      prev_fire = 0;
      prev_hold = 0;
    end else begin
      if (bus.t_wen) n_wen++;
      if (bus.t_start) begin n_start++; start_cyc = cyc; end
      if (bus.t_ren) n_ren++;
      if (bus.job_done) begin n_done++; done_cyc = cyc; end
      check_eq("t_wen_follows_accept", bus.t_wen, prev_fire);
      if (prev_fire) begin
        check_eq("t_data_in", bus.t_data_in, prev_din);
        check_eq("t_set", bus.t_set, prev_set);
        check_eq("t_depth", bus.t_depth, prev_dep);
        check_eq("t_width", bus.t_width, prev_wid);
      end
      if (prev_hold) begin
        check_eq("hold_valid", bus.out_valid, 1);
        check_eq("hold_data", bus.out_data, prev_odata);
      end
      if (bus.out_valid && !bus.out_ready) check_eq("t_ren_while_full", bus.t_ren, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_data", bus.out_data, e[DW-1:0]);
          check_eq("out_last", bus.out_last, e[DW]);
        end
      end
      prev_fire  = bus.in_valid & bus.in_ready;
      prev_din   = bus.in_data;
      prev_set   = drv_set;
      prev_dep   = drv_dep;
      prev_wid   = drv_wid;
      prev_hold  = bus.out_valid & !bus.out_ready;
      prev_odata = bus.out_data;
    end
  end

  // ---------------- host side ----------------
  bit last_err = 0;

  task automatic check_outs_zero(input string tag);
    check_eq({tag, "_ctl"}, {bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last, bus.job_done,
                             bus.job_err, bus.t_wen, bus.t_set, bus.t_relu, bus.t_start, bus.t_ren}, 0);
    check_eq({tag, "_data"}, {bus.out_data, bus.t_data_in}, 0);
    check_eq({tag, "_dims"}, {bus.t_depth, bus.t_width}, 0);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outs_zero("mid_job_reset");
    @(posedge clk); #1;
    reset     = 1'b0;
    stall_req = 0;
    exp_q.delete();
    last_err = 0;
  endtask

  // abort: 0 none, 1 reset during LOAD_B, 2 reset during READ
  task automatic run_job(input int q, input int r, input int k, input bit bias, input bit relu,
                         input int pct, input bit fixed, input bit hang_en, input int abort,
                         input bit stall);
    logic [DW-1:0]   ha[16], hb[16], hw[16], hs[48];
    logic [1:0]      hset[48];
    logic [DIMW-1:0] hdep[48], hwid[48];
    int nA, nB, nW, total, idx, s_wen, s_start, s_ren, s_done;
    bit legal, accepted, stalled;
    legal = (q >= 1 && q <= SIZE) && (r >= 1 && r <= SIZE) && (k >= 1 && k <= SIZE);
    for (int i = 0; i < 16; i++) begin
      ha[i] = fixed ? DW'(i + 1) : DW'($urandom);
      hb[i] = fixed ? DW'(i + 5) : DW'($urandom);
      hw[i] = DW'($urandom);
    end
    @(posedge clk); #1;
    jq = q; jr = r; jk = k; hang = hang_en;
    check_eq("job_err_sticky", bus.job_err, last_err);
    s_wen = n_wen; s_start = n_start; s_ren = n_ren; s_done = n_done;
    bus.cmd_valid = 1'b1;
    bus.cmd_q = DIMW'(q); bus.cmd_r = DIMW'(r); bus.cmd_k = DIMW'(k);
    bus.cmd_bias = bias; bus.cmd_relu = relu;
    accepted = 0;
    for (int g = 0; g < 50 && !accepted; g++) begin
      @(negedge clk);
      if (bus.cmd_ready) accepted = 1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    check_eq("cmd_accept", accepted, 1);

    if (!legal) begin
      @(negedge clk);
      check_eq("bad_dims_done", bus.job_done, 1);
      check_eq("bad_dims_err", bus.job_err, 1);
      repeat (4) @(negedge clk);
      check_eq("bad_dims_ndone", n_done - s_done, 1);
      check_eq("bad_dims_traffic", (n_wen - s_wen) + (n_start - s_start) + (n_ren - s_ren), 0);
      last_err = 1;
      return;
    end

    nA = q * r; nB = r * k; nW = bias ? q * k : 0;
    total = nA + nB + nW;
    for (int i = 0; i < total; i++) begin
      if (i < nA) begin
        hs[i] = ha[i]; hset[i] = 2'd0; hdep[i] = DIMW'(r); hwid[i] = DIMW'(q);
      end else if (i < nA + nB) begin
        hs[i] = hb[i-nA]; hset[i] = 2'd1; hdep[i] = DIMW'(k); hwid[i] = DIMW'(r);
      end else begin
        hs[i] = hw[i-nA-nB]; hset[i] = 2'd3; hdep[i] = DIMW'(k); hwid[i] = DIMW'(q);
      end
    end
    if (!hang_en)
      for (int i = 0; i < q; i++)
        for (int j = 0; j < k; j++)
          exp_q.push_back({(i == q - 1) && (j == k - 1), mac(ha, hb, hw, i, j, r, k, bias, relu)});

    idx = 0;
    for (int g = 0; g < 2000 && idx < total; g++) begin
      if (abort == 1 && idx == nA + 1) break;
      bus.in_valid = ($urandom_range(0, 99) < pct);
      bus.in_data  = hs[idx];
      drv_set = hset[idx]; drv_dep = hdep[idx]; drv_wid = hwid[idx];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (abort == 1) begin
      do_reset();
      return;
    end
    check_eq("load_all_accepted", idx, total);

    stalled = 0;
    for (int g = 0; g < TIMEOUT + 300 && n_done == s_done; g++) begin
      @(negedge clk);
      if (abort == 2 && bus.out_valid) begin
        do_reset();
        return;
      end
      if (stall && !stalled && (n_ren - s_ren) >= 2) begin
        stall_req = 5;
        stalled = 1;
      end
    end
    check_eq("job_done_seen", n_done != s_done, 1);
    repeat (3) @(negedge clk);
    check_eq("job_done_once", n_done - s_done, 1);
    check_eq("job_err", bus.job_err, hang_en);
    check_eq("n_t_wen", n_wen - s_wen, total);
    check_eq("n_t_start", n_start - s_start, 1);
    check_eq("n_t_ren", n_ren - s_ren, hang_en ? 0 : q * k);
    check_eq("results_drained", exp_q.size(), 0);
    if (hang_en) check_eq("timeout_latency", done_cyc - start_cyc, TIMEOUT);
    last_err = hang_en;
    hang = 0;
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_q = '0; bus.cmd_r = '0; bus.cmd_k = '0;
    bus.cmd_bias = 1'b0; bus.cmd_relu = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    drv_set = '0; drv_dep = '0; drv_wid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    run_job(2, 2, 2, 0, 0, 100, 1, 0, 0, 0);   // directed 2x2x2
    run_job(1, 4, 3, 1, 0, 50, 0, 0, 0, 0);    // bias, bursty input
    run_job(0, 2, 2, 0, 0, 100, 0, 0, 0, 0);   // q = 0
    run_job(2, 2, SIZE + 1, 0, 0, 100, 0, 0, 0, 0); // k = SIZE+1
    run_job(2, 2, 2, 0, 1, 100, 0, 1, 0, 0);   // accelerator never finishes
    run_job(3, 3, 3, 0, 1, 100, 0, 0, 0, 1);   // consumer stall mid-stream
    run_job(2, 3, 2, 1, 0, 100, 0, 0, 1, 0);   // reset during LOAD_B
    run_job(2, 2, 2, 0, 0, 100, 0, 0, 2, 0);   // reset during READ
    run_job(2, 2, 2, 0, 0, 100, 1, 0, 0, 0);   // clean job after resets
    rdy_rand = 1;
    for (int n = 0; n < 25; n++)
      run_job($urandom_range(1, SIZE), $urandom_range(1, SIZE), $urandom_range(1, SIZE),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(30, 100),
              0, 0, 0, 0);
    check_eq("t_start_while_busy", busy_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
